// File: rtl/shift_issue_stage_if.sv
// Bundles the three handshake groups of the shift issue stage: instruction in,
// shifter drive/return, and the write-back entry out.
interface shift_issue_stage_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [5:0]        in_funct;
   logic [4:0]        in_shamt;
   logic [DATA_W-1:0] in_rs;
   logic [DATA_W-1:0] in_rt;
   logic [4:0]        in_rd;

   logic [DATA_W-1:0] sh_operand;
   logic [5:0]        sh_amt;
   logic [5:0]        sh_v_amt;
   logic [2:0]        sh_cont;
   logic [DATA_W-1:0] sh_result;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [4:0]        out_rd;
   logic              out_we;
   logic              out_illegal;

   // Upstream/environment side
   modport master (
      output in_valid, in_funct, in_shamt, in_rs, in_rt, in_rd,
      input  in_ready,
      input  sh_operand, sh_amt, sh_v_amt, sh_cont,
      output sh_result,
      input  out_valid, out_result, out_rd, out_we, out_illegal,
      output out_ready
   );

   // Stage side
   modport slave (
      input  in_valid, in_funct, in_shamt, in_rs, in_rt, in_rd,
      output in_ready,
      output sh_operand, sh_amt, sh_v_amt, sh_cont,
      input  sh_result,
      output out_valid, out_result, out_rd, out_we, out_illegal,
      input  out_ready
   );
endinterface

// File: rtl/shift_issue_stage.sv
// Two-stage issue/write-back pipeline around an external combinational shifter.
// Define SHIFT_ISSUE_STATS_EN to add retired/stall counters (stat_retired, stat_stall).
module shift_issue_stage #(
   parameter int DATA_W = 32,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
`ifdef SHIFT_ISSUE_STATS_EN
   output logic [STAT_W-1:0] stat_retired,
   output logic [STAT_W-1:0] stat_stall,
`endif
   shift_issue_stage_if.slave bus
);

   localparam logic [2:0] CONT_NULL = 3'b100;

   logic              s1_valid_q, s1_valid_d;
   logic [2:0]        s1_cont_q, s1_cont_d;
   logic [4:0]        s1_shamt_q, s1_shamt_d;
   logic [4:0]        s1_vamt_q, s1_vamt_d;
   logic [DATA_W-1:0] s1_rt_q, s1_rt_d;
   logic [4:0]        s1_rd_q, s1_rd_d;
   logic              s1_ill_q, s1_ill_d;

   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_result_q, s2_result_d;
   logic [4:0]        s2_rd_q, s2_rd_d;
   logic              s2_ill_q, s2_ill_d;

   logic              s1_adv;
   logic              in_fire;
   logic              out_fire;
   logic [2:0]        dec_cont;
   logic              dec_ill;

   // Only rs[4:0] is a shift amount; the rest of rs is deliberately dropped.
   logic unused_rs_hi;
   assign unused_rs_hi = ^bus.in_rs[DATA_W-1:5];

   assign out_fire     = s2_valid_q && bus.out_ready;
   assign s1_adv       = s1_valid_q && (!s2_valid_q || bus.out_ready);
   assign bus.in_ready = !s1_valid_q || s1_adv;
   assign in_fire      = bus.in_valid && bus.in_ready;

   always_comb begin
      dec_cont = CONT_NULL;
      dec_ill  = 1'b1;
      case (bus.in_funct)
         6'b000000: begin dec_cont = 3'b000; dec_ill = 1'b0; end
         6'b000010: begin dec_cont = 3'b010; dec_ill = 1'b0; end
         6'b000011: begin dec_cont = 3'b110; dec_ill = 1'b0; end
         6'b000100: begin dec_cont = 3'b001; dec_ill = 1'b0; end
         6'b000110: begin dec_cont = 3'b011; dec_ill = 1'b0; end
         6'b000111: begin dec_cont = 3'b111; dec_ill = 1'b0; end
         default:   begin dec_cont = CONT_NULL; dec_ill = 1'b1; end
      endcase
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_cont_d   = s1_cont_q;
      s1_shamt_d  = s1_shamt_q;
      s1_vamt_d   = s1_vamt_q;
      s1_rt_d     = s1_rt_q;
      s1_rd_d     = s1_rd_q;
      s1_ill_d    = s1_ill_q;
      s2_valid_d  = s2_valid_q;
      s2_result_d = s2_result_q;
      s2_rd_d     = s2_rd_q;
      s2_ill_d    = s2_ill_q;

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_cont_d  = dec_cont;
         s1_shamt_d = bus.in_shamt;
         s1_vamt_d  = bus.in_rs[4:0];
         s1_rt_d    = bus.in_rt;
         s1_rd_d    = bus.in_rd;
         s1_ill_d   = dec_ill;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      // A refill on the same edge as a drain keeps the entry valid with new data.
      if (s1_adv) begin
         s2_valid_d  = 1'b1;
         s2_result_d = bus.sh_result;
         s2_rd_d     = s1_rd_q;
         s2_ill_d    = s1_ill_q;
      end else if (out_fire) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_cont_q   <= 3'b000;
         s1_shamt_q  <= 5'd0;
         s1_vamt_q   <= 5'd0;
         s1_rt_q     <= '0;
         s1_rd_q     <= 5'd0;
         s1_ill_q    <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_rd_q     <= 5'd0;
         s2_ill_q    <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_cont_q   <= s1_cont_d;
         s1_shamt_q  <= s1_shamt_d;
         s1_vamt_q   <= s1_vamt_d;
         s1_rt_q     <= s1_rt_d;
         s1_rd_q     <= s1_rd_d;
         s1_ill_q    <= s1_ill_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_rd_q     <= s2_rd_d;
         s2_ill_q    <= s2_ill_d;
      end
   end

   assign bus.sh_operand  = s1_rt_q;
   assign bus.sh_amt      = {1'b0, s1_shamt_q};
   assign bus.sh_v_amt    = {1'b0, s1_vamt_q};
   assign bus.sh_cont     = s1_valid_q ? s1_cont_q : CONT_NULL;

   assign bus.out_valid   = s2_valid_q;
   assign bus.out_result  = s2_result_q;
   assign bus.out_rd      = s2_rd_q;
   assign bus.out_illegal = s2_ill_q;
   assign bus.out_we      = s2_valid_q && !s2_ill_q && (s2_rd_q != 5'd0);

`ifdef SHIFT_ISSUE_STATS_EN
   logic [STAT_W-1:0] stat_retired_q, stat_retired_d;
   logic [STAT_W-1:0] stat_stall_q, stat_stall_d;

   always_comb begin
      stat_retired_d = stat_retired_q;
      stat_stall_d   = stat_stall_q;
      if (out_fire) begin
         stat_retired_d = stat_retired_q + 1'b1;
      end
      if (s2_valid_q && !bus.out_ready) begin
         stat_stall_d = stat_stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_retired_q <= '0;
         stat_stall_q   <= '0;
      end else begin
         stat_retired_q <= stat_retired_d;
         stat_stall_q   <= stat_stall_d;
      end
   end

   assign stat_retired = stat_retired_q;
   assign stat_stall   = stat_stall_q;
`else
   // Counter width only matters when the statistics are built in.
   localparam int unused_stat_w = STAT_W;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage with a behavioural shifter closing the
// sh_* loop; each comparison is an immediate assertion.
module tb_shift_issue_stage;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   shift_issue_stage_if #(.DATA_W(32)) bus ();

`ifdef SHIFT_ISSUE_STATS_EN
   logic [15:0] stat_retired;
   logic [15:0] stat_stall;
`endif

   shift_issue_stage #(.DATA_W(32), .STAT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
`ifdef SHIFT_ISSUE_STATS_EN
      .stat_retired (stat_retired),
      .stat_stall   (stat_stall),
`endif
      .bus          (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference shifter: bit0 selects the variable amount, bit1 right, bit2 arithmetic.
   always_comb begin
      case (bus.sh_cont)
         3'b000:  bus.sh_result = bus.sh_operand << bus.sh_amt;
         3'b001:  bus.sh_result = bus.sh_operand << bus.sh_v_amt;
         3'b010:  bus.sh_result = bus.sh_operand >> bus.sh_amt;
         3'b011:  bus.sh_result = bus.sh_operand >> bus.sh_v_amt;
         3'b110:  bus.sh_result = $unsigned($signed(bus.sh_operand) >>> bus.sh_amt);
         3'b111:  bus.sh_result = $unsigned($signed(bus.sh_operand) >>> bus.sh_v_amt);
         default: bus.sh_result = bus.sh_operand;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic drive(input logic [5:0] funct, input logic [4:0] shamt,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
      bus.in_valid = 1'b1;
      bus.in_funct = funct;
      bus.in_shamt = shamt;
      bus.in_rs    = rs;
      bus.in_rt    = rt;
      bus.in_rd    = rd;
      $display("drive funct=%b shamt=%0d rs=0x%08h rt=0x%08h rd=%0d", funct, shamt, rs, rt, rd);
   endtask

   task automatic idle;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_funct  = 6'd0;
      bus.in_shamt  = 5'd0;
      bus.in_rs     = 32'd0;
      bus.in_rt     = 32'd0;
      bus.in_rd     = 5'd0;
      bus.out_ready = 1'b1;

      // Reset state, during and after reset
      tick; tick;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_result", bus.out_result, 0);
      chk("rst_sh_cont", bus.sh_cont, 3'b100);
      reset = 1'b0;
      tick;
      chk("post_rst_out_valid", bus.out_valid, 0);
      chk("post_rst_out_we", bus.out_we, 0);
      chk("post_rst_out_illegal", bus.out_illegal, 0);
      chk("post_rst_out_rd", bus.out_rd, 0);
      chk("post_rst_sh_operand", bus.sh_operand, 0);
      chk("post_rst_sh_amt", bus.sh_amt, 0);
      chk("post_rst_sh_v_amt", bus.sh_v_amt, 0);

      // Single sll: shamt 4 on 0xF1 -> 0xF10, rd 3
      drive(6'b000000, 5'd4, 32'h0, 32'h0000_00F1, 5'd3);
      tick; idle; settle;
      chk("sll_sh_cont", bus.sh_cont, 3'b000);
      chk("sll_sh_amt", bus.sh_amt, 6'd4);
      chk("sll_sh_operand", bus.sh_operand, 32'h0000_00F1);
      chk("sll_out_valid_early", bus.out_valid, 0);
      tick;
      chk("sll_out_valid", bus.out_valid, 1);
      chk("sll_out_result", bus.out_result, 32'h0000_0F10);
      chk("sll_out_rd", bus.out_rd, 3);
      chk("sll_out_we", bus.out_we, 1);
      chk("sll_out_illegal", bus.out_illegal, 0);
      tick;
      chk("sll_drained", bus.out_valid, 0);
      chk("sll_sh_cont_null", bus.sh_cont, 3'b100);
      $display("txn sll result=0x%08h rd=%0d", 32'h0000_0F10, 3);

      // srav: rs=0x24 -> amount 4 (rs[5] ignored); 0x80000000 >>> 4 = 0xF8000000
      drive(6'b000111, 5'd9, 32'h0000_0024, 32'h8000_0000, 5'd7);
      tick; idle; settle;
      chk("srav_sh_cont", bus.sh_cont, 3'b111);
      chk("srav_sh_v_amt", bus.sh_v_amt, 6'd4);
      tick;
      chk("srav_out_result", bus.out_result, 32'hF800_0000);
      chk("srav_out_rd", bus.out_rd, 7);
      chk("srav_out_we", bus.out_we, 1);
      tick;
      $display("txn srav result=0x%08h rd=%0d", 32'hF800_0000, 7);

      // Illegal funct, rd 5
      drive(6'b100000, 5'd2, 32'h0, 32'h1234_5678, 5'd5);
      tick; idle; settle;
      chk("ill_sh_cont", bus.sh_cont, 3'b100);
      tick;
      chk("ill_out_valid", bus.out_valid, 1);
      chk("ill_out_illegal", bus.out_illegal, 1);
      chk("ill_out_we", bus.out_we, 0);
      chk("ill_out_rd", bus.out_rd, 5);
      tick;
      chk("ill_one_transfer", bus.out_valid, 0);
      $display("txn illegal rd=%0d", 5);

      // sll into r0: no write enable
      drive(6'b000000, 5'd1, 32'h0, 32'h0000_0001, 5'd0);
      tick; idle; tick;
      chk("r0_out_valid", bus.out_valid, 1);
      chk("r0_out_result", bus.out_result, 32'h0000_0002);
      chk("r0_out_we", bus.out_we, 0);
      tick;
      $display("txn sll rd=0 result=0x%08h", 32'h0000_0002);

      // 8 back-to-back sll ops: op j = 1 << j to rd j+1, visible two edges after offer
      for (int i = 0; i < 10; i++) begin
         if (i < 8) drive(6'b000000, 5'(i), 32'h0, 32'h0000_0001, 5'(i + 1));
         else idle;
         settle;
         if (i < 8) chk("stream_in_ready", bus.in_ready, 1);
         if (i >= 2) begin
            chk("stream_out_valid", bus.out_valid, 1);
            chk("stream_out_result", bus.out_result, 32'h1 << (i - 2));
            chk("stream_out_rd", bus.out_rd, 32'(i - 1));
            $display("txn stream op=%0d result=0x%08h", i - 2, 32'h1 << (i - 2));
         end
         tick;
      end
      chk("stream_end", bus.out_valid, 0);

      // Reset mid-stream with both stages full
      bus.out_ready = 1'b0;
      drive(6'b000010, 5'd1, 32'h0, 32'h0000_0100, 5'd4);
      tick;
      drive(6'b000010, 5'd2, 32'h0, 32'h0000_0100, 5'd6);
      tick; idle; settle;
      chk("full_in_ready", bus.in_ready, 0);
      chk("full_out_valid", bus.out_valid, 1);
      reset = 1'b1;
      settle;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      chk("midrst_sh_cont", bus.sh_cont, 3'b100);
      tick;
      reset = 1'b0;
      bus.out_ready = 1'b1;
      tick; tick;
      chk("midrst_no_output", bus.out_valid, 0);
      $display("txn mid-stream reset");

      // Backpressure: out_ready low, 3 ops offered, only 2 fit
      bus.out_ready = 1'b0;
      drive(6'b000010, 5'd4, 32'h0, 32'h0000_00F0, 5'd9);        // srl -> 0xF
      settle;
      chk("bp_accept0", bus.in_ready, 1);
      tick;
      drive(6'b000100, 5'd0, 32'h0000_0003, 32'h0000_0001, 5'd10); // sllv -> 0x8
      settle;
      chk("bp_accept1", bus.in_ready, 1);
      tick;
      drive(6'b000110, 5'd0, 32'hFFFF_FF21, 32'h8000_0000, 5'd11); // srlv by 1 -> 0x40000000
      for (int k = 0; k < 5; k++) begin
         settle;
         chk("bp_in_ready_low", bus.in_ready, 0);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_out_result", bus.out_result, 32'h0000_000F);
         chk("bp_out_rd", bus.out_rd, 9);
         tick;
      end
      bus.out_ready = 1'b1;
      settle;
      chk("bp_release_in_ready", bus.in_ready, 1);
      $display("txn drain rd=9 result=0x%08h", 32'h0000_000F);
      tick; idle; settle;
      chk("bp_drain1_valid", bus.out_valid, 1);
      chk("bp_drain1_result", bus.out_result, 32'h0000_0008);
      chk("bp_drain1_rd", bus.out_rd, 10);
      $display("txn drain rd=10 result=0x%08h", 32'h0000_0008);
      tick;
      chk("bp_drain2_valid", bus.out_valid, 1);
      chk("bp_drain2_result", bus.out_result, 32'h4000_0000);
      chk("bp_drain2_rd", bus.out_rd, 11);
      $display("txn drain rd=11 result=0x%08h", 32'h4000_0000);
      tick;
      chk("bp_empty", bus.out_valid, 0);
`ifdef SHIFT_ISSUE_STATS_EN
      chk("stat_stall", stat_stall, 5);
      chk("stat_retired", stat_retired, 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Execute-stage front end and back end for the shifter ALU.
- Accepts decoded R-type shift instructions: funct, shamt, rs and rt values, and destination rd, through a valid/ready handshake.
- Registers each instruction, translates funct into the shifter's 3-bit control code and drives the shifter combinationally.
- Captures the shifter result into a write-back register with its own valid/ready handshake. Two-stage pipeline, one instruction per cycle at full throughput.

Parameters:
- DATA_W, 32: operand/result width.
- STAT_W, 16: width of the optional statistics counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept the instruction this cycle.
- in_funct  input  6  MIPS funct field.
- in_shamt  input  5  immediate shift amount.
- in_rs  input  DATA_W  rs register value (variable shift amount source).
- in_rt  input  DATA_W  rt register value (shift operand).
- in_rd  input  5  destination register.
- sh_operand  output  DATA_W  to shifter operand.
- sh_amt  output  6  to shifter, {1'b0, shamt}.
- sh_v_amt  output  6  to shifter, {1'b0, rs[4:0]}.
- sh_cont  output  3  to shifter control.
- sh_result  input  DATA_W  from shifter, combinational in sh_* outputs.
- out_valid  output  1  write-back entry valid.
- out_ready  input  1  downstream accepts the entry.
- out_result  output  DATA_W  shift result.
- out_rd  output  5  destination register.
- out_we  output  1  register write enable.
- out_illegal  output  1  funct was not a shift.

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0, all data registers 0. Outputs during and after reset until first accept:
  - in_ready=1
  - out_valid=0, out_result=0, out_rd=0, out_we=0, out_illegal=0
  - sh_operand=0, sh_amt=0, sh_v_amt=0
  - sh_cont=3'b100 (null code)
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Input fields must be stable only in the cycle of transfer.
- Stage 1 (issue register):
  - Holds funct-decoded control, shamt, rs[4:0], rt, rd, illegal flag.
  - s1_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s1_adv, combinational and depends on out_ready.
- Funct decode, registered at accept:
  - 000000 sll -> 000
  - 000010 srl -> 010
  - 000011 sra -> 110
  - 000100 sllv -> 001
  - 000110 srlv -> 011
  - 000111 srav -> 111
  - Any other funct -> 100 with illegal=1.
- sh_* outputs come straight from stage-1 registers. While s1_valid=0, sh_cont=100 and the other sh_* outputs hold their last values.
- Stage 2 (write-back register): on s1_adv, loads sh_result, rd and illegal; s2_valid=1.
  - If out_valid && out_ready with no s1_adv, s2_valid=0.
  - Simultaneous drain and refill keeps s2_valid=1 with the new data.
- out_we = s2_valid && !illegal && (rd != 0).
- Latency: instruction accepted at edge N appears at out_valid after edge N+1. Sustained throughput 1/cycle while out_ready=1.
- Backpressure: with out_ready=0 and both stages full, in_ready=0. No data is lost or duplicated, and out_* hold stable.
- Variable amount uses rs[4:0] only; rs[31:5] are ignored.
- Reset mid-operation discards both stages immediately (async).

Optional Feature:
- Macro SHIFT_ISSUE_STATS_EN.
- When defined, adds outputs stat_retired [STAT_W] and stat_stall [STAT_W]:
  - stat_retired increments on each output transfer.
  - stat_stall increments each cycle with out_valid && !out_ready.
  - Both counters wrap modulo 2^STAT_W and reset to 0.
- When not defined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset asserted mid-stream with both stages full -> same cycle: out_valid=0, in_ready=1, sh_cont=100; no output after release until a new accept.
- Single sll: funct=000000, shamt=4, rt=0x0000_00F1, rd=3, out_ready=1 -> next cycle sh_cont=000, sh_amt=6'd4, sh_operand=0x0000_00F1. The bench shifter model returns 0x0000_0F10, which appears at out_result the following cycle with out_rd=3, out_we=1.
- Variable srav: funct=000111, rs=0x0000_0024, rt=0x8000_0000 -> sh_cont=111, sh_v_amt=6'd4 (upper rs bits ignored).
- Illegal funct 100000, rd=5 -> sh_cont=100, out_illegal=1, out_we=0, out_valid still asserted for one transfer. Also: sll with rd=0 -> out_we=0.
- Back-to-back stream of 8 ops with out_ready=1 -> 8 consecutive out_valid cycles, in order, in_ready never drops.
- Hold out_ready=0 for 5 cycles with 3 ops offered:
  - Exactly 2 ops accepted, then in_ready=0.
  - out_* stable throughout.
  - Releasing out_ready drains all 3 in order.
  - With SHIFT_ISSUE_STATS_EN: stat_stall=5, stat_retired=3.
